// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables, stage-valid tracking, operand select
// qualification and saturating stall/redirect event counters.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IFU_inst_valid,
  input  logic             IDU_rs1_used,
  input  logic             IDU_rs2_used,
  input  logic [1:0]       IDU_rs1_choice,
  input  logic [1:0]       IDU_rs2_choice,
  input  logic             EXU_mem_ren,
  input  logic             EXU_branch_taken,
  input  logic             MEM_mem_op,
  input  logic             MEM_dmem_ready,
  output logic             PC_en,
  output logic             IFU_IDU_en,
  output logic             IDU_EXU_en,
  output logic             EXU_MEM_en,
  output logic             MEM_WB_en,
  output logic             IDU_valid,
  output logic             EXU_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic [1:0]       IDU_rs1_sel,
  output logic [1:0]       IDU_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [1:0]       SEL_EX  = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;

  logic active;
  logic mem_wait;
  logic redirect;
  logic load_use;
  logic do_redirect;
  logic do_load_use;
  logic stall_event;

  // Events are only meaningful once the controller has left BOOT.
  assign active   = (state != BOOT);
  assign mem_wait = active & MEM_valid & MEM_mem_op & ~MEM_dmem_ready;
  assign redirect = active & EXU_valid & EXU_branch_taken;
  assign load_use = active & IDU_valid & EXU_valid & EXU_mem_ren &
                    ((IDU_rs1_used & (IDU_rs1_choice == SEL_EX)) |
                     (IDU_rs2_used & (IDU_rs2_choice == SEL_EX)));

  // Priority: memory freeze, then redirect, then load-use bubble.
  assign do_redirect = redirect & ~mem_wait;
  assign do_load_use = load_use & ~mem_wait & ~redirect;
  assign stall_event = mem_wait | do_load_use;

  assign IDU_rs1_sel = (IDU_valid & IDU_rs1_used & ~load_use) ? IDU_rs1_choice : 2'b00;
  assign IDU_rs2_sel = (IDU_valid & IDU_rs2_used & ~load_use) ? IDU_rs2_choice : 2'b00;

  always_comb begin
    PC_en      = 1'b0;
    IFU_IDU_en = 1'b0;
    IDU_EXU_en = 1'b0;
    EXU_MEM_en = 1'b0;
    MEM_WB_en  = 1'b0;
    if (active) begin
      if (mem_wait) begin
        MEM_WB_en = 1'b1;
      end else if (do_load_use) begin
        IDU_EXU_en = 1'b1;
        EXU_MEM_en = 1'b1;
        MEM_WB_en  = 1'b1;
      end else begin
        PC_en      = 1'b1;
        IFU_IDU_en = 1'b1;
        IDU_EXU_en = 1'b1;
        EXU_MEM_en = 1'b1;
        MEM_WB_en  = 1'b1;
      end
    end
  end

  // Control FSM and stage-valid bits; valids hold while in BOOT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      IDU_valid <= 1'b0;
      EXU_valid <= 1'b0;
      MEM_valid <= 1'b0;
      WB_valid  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN, MEM_WAIT: begin
          state <= mem_wait ? MEM_WAIT : RUN;
          if (mem_wait) begin
            WB_valid <= 1'b0;
          end else if (do_redirect) begin
            IDU_valid <= 1'b0;
            EXU_valid <= 1'b0;
            MEM_valid <= 1'b1;
            WB_valid  <= MEM_valid;
          end else if (do_load_use) begin
            EXU_valid <= 1'b0;
            MEM_valid <= 1'b1;
            WB_valid  <= MEM_valid;
          end else begin
            IDU_valid <= IFU_inst_valid;
            EXU_valid <= IDU_valid;
            MEM_valid <= EXU_valid;
            WB_valid  <= MEM_valid;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall_event && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (do_redirect && (redirect_cnt != CNT_MAX)) begin
        redirect_cnt <= redirect_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios plus randomized traffic
// compared against a stage-occupancy model of the pipeline.
module tb_pipe_ctrl;

  localparam int TB_CNT_W = 4;
  localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic       inst_valid;
    logic       rs1_used;
    logic       rs2_used;
    logic [1:0] rs1_choice;
    logic [1:0] rs2_choice;
    logic       mem_ren;
    logic       branch_taken;
    logic       mem_op;
    logic       dmem_ready;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic IFU_inst_valid = 1'b0;
  logic IDU_rs1_used = 1'b0;
  logic IDU_rs2_used = 1'b0;
  logic [1:0] IDU_rs1_choice = 2'b00;
  logic [1:0] IDU_rs2_choice = 2'b00;
  logic EXU_mem_ren = 1'b0;
  logic EXU_branch_taken = 1'b0;
  logic MEM_mem_op = 1'b0;
  logic MEM_dmem_ready = 1'b1;
  logic PC_en, IFU_IDU_en, IDU_EXU_en, EXU_MEM_en, MEM_WB_en;
  logic IDU_valid, EXU_valid, MEM_valid, WB_valid;
  logic [1:0] IDU_rs1_sel, IDU_rs2_sel;
  logic [TB_CNT_W-1:0] stall_cnt, redirect_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy of ID, EX, MEM, WB (index 0..3).
  bit mv[4];
  bit nv[4];
  bit m_boot;
  int m_stall, m_redir, n_stall, n_redir;
  logic [4:0] exp_en;
  logic [1:0] exp_sel1, exp_sel2;

  pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFU_inst_valid(IFU_inst_valid),
    .IDU_rs1_used(IDU_rs1_used), .IDU_rs2_used(IDU_rs2_used),
    .IDU_rs1_choice(IDU_rs1_choice), .IDU_rs2_choice(IDU_rs2_choice),
    .EXU_mem_ren(EXU_mem_ren), .EXU_branch_taken(EXU_branch_taken),
    .MEM_mem_op(MEM_mem_op), .MEM_dmem_ready(MEM_dmem_ready),
    .PC_en(PC_en), .IFU_IDU_en(IFU_IDU_en), .IDU_EXU_en(IDU_EXU_en),
    .EXU_MEM_en(EXU_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IDU_valid(IDU_valid), .EXU_valid(EXU_valid),
    .MEM_valid(MEM_valid), .WB_valid(WB_valid),
    .IDU_rs1_sel(IDU_rs1_sel), .IDU_rs2_sel(IDU_rs2_sel),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1;
  endfunction

  function automatic stim_t idle(input logic inst);
    stim_t s = '0;
    s.inst_valid = inst;
    s.dmem_ready = 1'b1;
    return s;
  endfunction

  // Expected combinational outputs and next model state for one cycle.
  task automatic modelEval(input stim_t s);
    bit mw, rd, lu;
    nv = mv;
    n_stall = m_stall;
    n_redir = m_redir;
    mw = !m_boot && mv[2] && s.mem_op && !s.dmem_ready;
    rd = !m_boot && mv[1] && s.branch_taken;
    lu = !m_boot && mv[0] && mv[1] && s.mem_ren &&
         ((s.rs1_used && s.rs1_choice == 2'b01) || (s.rs2_used && s.rs2_choice == 2'b01));
    exp_sel1 = (mv[0] && s.rs1_used && !lu) ? s.rs1_choice : 2'b00;
    exp_sel2 = (mv[0] && s.rs2_used && !lu) ? s.rs2_choice : 2'b00;
    if (m_boot) begin
      exp_en = 5'b00000;
    end else if (mw) begin
      exp_en = 5'b00001;
      nv[3] = 1'b0;
      n_stall = sat(m_stall);
    end else if (rd) begin
      exp_en = 5'b11111;
      nv[3] = mv[2]; nv[2] = 1'b1; nv[1] = 1'b0; nv[0] = 1'b0;
      n_redir = sat(m_redir);
    end else if (lu) begin
      exp_en = 5'b00111;
      nv[3] = mv[2]; nv[2] = 1'b1; nv[1] = 1'b0;
      n_stall = sat(m_stall);
    end else begin
      exp_en = 5'b11111;
      for (int i = 3; i > 0; i--) nv[i] = mv[i-1];
      nv[0] = s.inst_valid;
    end
  endtask

  task automatic checkRegs();
    checkOutput("valids", {28'd0, IDU_valid, EXU_valid, MEM_valid, WB_valid},
                {28'd0, mv[0], mv[1], mv[2], mv[3]});
    checkOutput("stall_cnt", {28'd0, stall_cnt}, m_stall);
    checkOutput("redirect_cnt", {28'd0, redirect_cnt}, m_redir);
  endtask

  task automatic applyStimulus(input stim_t s);
    IFU_inst_valid   = s.inst_valid;
    IDU_rs1_used     = s.rs1_used;
    IDU_rs2_used     = s.rs2_used;
    IDU_rs1_choice   = s.rs1_choice;
    IDU_rs2_choice   = s.rs2_choice;
    EXU_mem_ren      = s.mem_ren;
    EXU_branch_taken = s.branch_taken;
    MEM_mem_op       = s.mem_op;
    MEM_dmem_ready   = s.dmem_ready;
    modelEval(s);
    #1;
    checkOutput("enables", {27'd0, PC_en, IFU_IDU_en, IDU_EXU_en, EXU_MEM_en, MEM_WB_en},
                {27'd0, exp_en});
    checkOutput("rs1_sel", {30'd0, IDU_rs1_sel}, {30'd0, exp_sel1});
    checkOutput("rs2_sel", {30'd0, IDU_rs2_sel}, {30'd0, exp_sel2});
    @(posedge clk);
    #1;
    mv = nv;
    m_stall = n_stall;
    m_redir = n_redir;
    m_boot = 1'b0;
    checkRegs();
  endtask

  // Asynchronous reset asserted away from the clock edge, checked at once.
  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    m_boot = 1'b1;
    m_stall = 0;
    m_redir = 0;
    checkRegs();
    checkOutput("rst_enables", {27'd0, PC_en, IFU_IDU_en, IDU_EXU_en, EXU_MEM_en, MEM_WB_en}, 0);
    checkOutput("rst_sels", {28'd0, IDU_rs1_sel, IDU_rs2_sel}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic fill();
    repeat (4) applyStimulus(idle(1'b1));
  endtask

  initial begin
    stim_t s;
    m_boot = 1'b1;
    m_stall = 0;
    m_redir = 0;
    doReset();

    // Valids ripple in after a single BOOT cycle.
    applyStimulus(idle(1'b1));
    checkOutput("boot_idu_valid", {31'd0, IDU_valid}, 0);
    applyStimulus(idle(1'b1));
    checkOutput("c2_idu_valid", {31'd0, IDU_valid}, 1);
    applyStimulus(idle(1'b1));
    checkOutput("c3_exu_valid", {31'd0, EXU_valid}, 1);
    applyStimulus(idle(1'b1));
    checkOutput("c4_mem_valid", {31'd0, MEM_valid}, 1);
    applyStimulus(idle(1'b1));
    checkOutput("c5_wb_valid", {31'd0, WB_valid}, 1);

    // Load-use: one bubble, then forwarding from load data.
    doReset();
    fill();
    s = idle(1'b1);
    s.mem_ren = 1'b1; s.rs1_used = 1'b1; s.rs1_choice = 2'b01;
    applyStimulus(s);
    checkOutput("lu_exu_bubble", {31'd0, EXU_valid}, 0);
    checkOutput("lu_stall_cnt", {28'd0, stall_cnt}, 1);
    s.mem_ren = 1'b0; s.rs1_choice = 2'b11;
    applyStimulus(s);
    checkOutput("lu_fwd_sel", {30'd0, IDU_rs1_sel}, 3);

    // Taken branch flushes ID and EX.
    doReset();
    fill();
    s = idle(1'b1);
    s.branch_taken = 1'b1;
    applyStimulus(s);
    checkOutput("br_flush", {29'd0, IDU_valid, EXU_valid, MEM_valid}, 3'b001);
    checkOutput("br_redirect_cnt", {28'd0, redirect_cnt}, 1);

    // Store held in MEM for three cycles.
    doReset();
    fill();
    s = idle(1'b1);
    s.mem_op = 1'b1; s.dmem_ready = 1'b0;
    repeat (3) applyStimulus(s);
    checkOutput("mw_stall_cnt", {28'd0, stall_cnt}, 3);
    checkOutput("mw_wb_valid", {31'd0, WB_valid}, 0);
    s.dmem_ready = 1'b1;
    applyStimulus(s);

    // Freeze outranks redirect and load-use; redirect lands after ready.
    doReset();
    fill();
    s = idle(1'b1);
    s.mem_op = 1'b1; s.dmem_ready = 1'b0; s.branch_taken = 1'b1;
    s.mem_ren = 1'b1; s.rs1_used = 1'b1; s.rs1_choice = 2'b01;
    repeat (2) applyStimulus(s);
    checkOutput("prio_redirect_cnt", {28'd0, redirect_cnt}, 0);
    checkOutput("prio_stall_cnt", {28'd0, stall_cnt}, 2);
    s.dmem_ready = 1'b1;
    applyStimulus(s);
    checkOutput("prio_redirect_after", {28'd0, redirect_cnt}, 1);
    checkOutput("prio_idu_flushed", {31'd0, IDU_valid}, 0);

    // Stall counter saturation, then reset in the middle of a freeze.
    doReset();
    s = idle(1'b1);
    s.mem_ren = 1'b1; s.rs1_used = 1'b1; s.rs1_choice = 2'b01;
    repeat (45) applyStimulus(s);
    checkOutput("sat_stall_cnt", {28'd0, stall_cnt}, CNT_SAT);
    repeat (3) applyStimulus(idle(1'b1));
    s = idle(1'b1);
    s.mem_op = 1'b1; s.dmem_ready = 1'b0;
    repeat (2) applyStimulus(s);
    doReset();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      s.inst_valid   = 1'($urandom_range(0, 3) != 0);
      s.rs1_used     = 1'($urandom_range(0, 1));
      s.rs2_used     = 1'($urandom_range(0, 1));
      s.rs1_choice   = 2'($urandom_range(0, 3));
      s.rs2_choice   = 2'($urandom_range(0, 3));
      s.mem_ren      = 1'($urandom_range(0, 2) == 0);
      s.branch_taken = 1'($urandom_range(0, 7) == 0);
      s.mem_op       = 1'($urandom_range(0, 2) == 0);
      s.dmem_ready   = 1'($urandom_range(0, 3) != 0);
      applyStimulus(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall and redirect event counters.
REQ-002 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 IFU_inst_valid  in  1  fetch presents a valid instruction this cycle.
REQ-005 IDU_rs1_used, IDU_rs2_used  in  1 each  decoded instruction reads rs1/rs2.
REQ-006 IDU_rs1_choice, IDU_rs2_choice  in  2 each  from the hazard unit: 00 regfile, 01 EX result, 10 MEM ALU result, 11 MEM load data.
REQ-007 EXU_mem_ren  in  1  instruction in EX is a load.
REQ-008 EXU_branch_taken  in  1  taken branch/jump resolved in EX.
REQ-009 MEM_mem_op  in  1  instruction in MEM is a load or store.
REQ-010 MEM_dmem_ready  in  1  data memory access completes this cycle.
REQ-011 PC_en, IFU_IDU_en, IDU_EXU_en, EXU_MEM_en, MEM_WB_en  out  1 each  pipeline register enables.
REQ-012 IDU_valid, EXU_valid, MEM_valid, WB_valid  out  1 each  registered stage-valid bits.
REQ-013 IDU_rs1_sel, IDU_rs2_sel  out  2 each  qualified operand selects.
REQ-014 stall_cnt, redirect_cnt  out  CNT_W each  saturating event counters.

Function
REQ-015 FSM states BOOT, RUN, MEM_WAIT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-016 In BOOT all enables SHALL be 0 and no valid bit SHALL change.
REQ-017 mem_wait = MEM_valid & MEM_mem_op & ~MEM_dmem_ready; RUN->MEM_WAIT on mem_wait, MEM_WAIT->RUN in the cycle MEM_dmem_ready rises.
REQ-018 load_use = IDU_valid & EXU_valid & EXU_mem_ren & ((IDU_rs1_used & rs1_choice==01) | (IDU_rs2_used & rs2_choice==01)).
REQ-019 redirect = EXU_valid & EXU_branch_taken.
REQ-020 Priority mem_wait > redirect > load_use; lower-priority events are ignored in the same cycle.
REQ-021 mem_wait: all enables 0 except MEM_WB_en=1; IDU/EXU/MEM_valid hold; WB_valid<=0.
REQ-022 redirect: all enables 1; IDU_valid<=0, EXU_valid<=0, MEM_valid<=1, WB_valid<=MEM_valid.
REQ-023 load_use: PC_en=0, IFU_IDU_en=0, others 1; IDU_valid holds, EXU_valid<=0 (bubble), MEM_valid<=1, WB_valid<=MEM_valid.
REQ-024 Otherwise (RUN): all enables 1; IDU_valid<=IFU_inst_valid, EXU_valid<=IDU_valid, MEM_valid<=EXU_valid, WB_valid<=MEM_valid.
REQ-025 A load_use stall lasts exactly one cycle unless extended by mem_wait; the next cycle the hazard unit reports 11 and issue proceeds.
REQ-026 IDU_rsX_sel = rsX_choice when IDU_valid & IDU_rsX_used & ~load_use, else 00 (combinational).
REQ-027 stall_cnt increments by 1 each RUN/MEM_WAIT cycle with mem_wait or load_use asserted; redirect_cnt increments on each redirect cycle; both saturate at 2^CNT_W-1, no wrap.
REQ-028 Enables and selects are combinational from state and inputs; valids and counters are registered.

Reset
REQ-029 rst_n low SHALL immediately force state BOOT, all valids 0, both counters 0, all enables 0, selects 00.
REQ-030 Reset asserted mid-stall SHALL abandon the stall; no event is counted in the reset cycle.

Verification
REQ-031 Reset release, IFU_inst_valid=1 constant -> BOOT 1 cycle, then IDU/EXU/MEM/WB_valid rise on consecutive cycles 2..5.
REQ-032 lw x5 in EX, ID uses rs1 with choice 01 -> PC_en=IFU_IDU_en=0 one cycle, EXU_valid=0 next, stall_cnt=1, then choice 11 forwarded as sel 11.
REQ-033 Taken branch in EX with valid ID -> IDU_valid=0 and EXU_valid=0 next cycle, redirect_cnt=1, MEM_valid=1.
REQ-034 Store in MEM, MEM_dmem_ready low 3 cycles -> state MEM_WAIT, enables 0 except MEM_WB_en for 3 cycles, WB_valid=0, stall_cnt=3.
REQ-035 mem_wait with simultaneous redirect and load_use -> only freeze applied, redirect_cnt unchanged; redirect takes effect after ready.
REQ-036 CNT_W=4, 20 load_use stalls -> stall_cnt saturates at 15; rst_n pulse mid-MEM_WAIT -> all outputs at reset values immediately.
